uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling on a 16x baud clock enable.
// Mid-bit sampling, glitch reject on the start bit, single-byte holding register with ready/ack.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce16_i,
    input  logic       ser_in,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_ready_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             tick_reg, tick_next;
    logic [2:0]             bit_reg, bit_next;
    logic [7:0]             shift_reg, shift_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_bit;
    logic                   done_ok;
    logic                   done_err;

    // Synchronizer chain, idles high so reset does not look like a start bit
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= ser_in;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_bit = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tick_reg  <= 4'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        if (ce16_i) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_bit) begin
                        state_next = START;
                        tick_next  = 4'd0;
                    end
                end
                START: begin
                    if (tick_reg == 4'd7) begin
                        tick_next = 4'd0;
                        bit_next  = 3'd0;
                        // A line already back high at mid start bit was only a glitch
                        state_next = rx_bit ? IDLE : DATA;
                    end else begin
                        tick_next = tick_reg + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_reg == 4'd15) begin
                        tick_next  = 4'd0;
                        shift_next = {rx_bit, shift_reg[7:1]};
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) state_next = STOP;
                    end else begin
                        tick_next = tick_reg + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_reg == 4'd15) begin
                        tick_next  = 4'd0;
                        state_next = IDLE;
                        done_ok    = rx_bit;
                        done_err   = !rx_bit;
                    end else begin
                        tick_next = tick_reg + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A completing byte wins over a same-cycle ack, so ready stays set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_o   <= 8'h00;
            rx_ready_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= done_err;
            overrun_o   <= done_ok && rx_ready_o && !rx_ack_i;
            if (done_ok) begin
                rx_data_o  <= shift_reg;
                rx_ready_o <= 1'b1;
            end else if (rx_ack_i) begin
                rx_ready_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are modelled as byte-level events,
// a monitor pops the expected event whenever the receiver reports a completion.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       ce16_i;
    logic       ser_in;
    logic       rx_ack_i;
    logic [7:0] rx_data_o;
    logic       rx_ready_o;
    logic       frame_err_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;

    // kind: 1 frame error, 2 overrun load, 3 clean load
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       ready;
    } ev_t;

    ev_t        exp_q[$];
    logic       model_ready;
    logic [7:0] model_data;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce16_i      (ce16_i),
        .ser_in      (ser_in),
        .rx_ack_i    (rx_ack_i),
        .rx_data_o   (rx_data_o),
        .rx_ready_o  (rx_ready_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bit cell = ntk ticks of ce16_i, one tick every 4 clocks; line changes with tick 0
    task automatic send_bit(input logic b, input int ack_tick, input bit ack_chk,
                            input int lat_tick, input logic lat_exp, input int ntk);
        for (int t = 0; t < ntk; t++) begin
            @(negedge clk);
            ser_in   = b;
            ce16_i   = 1'b1;
            rx_ack_i = (t == ack_tick);
            @(negedge clk);
            ce16_i   = 1'b0;
            rx_ack_i = 1'b0;
            if (t == lat_tick) check("LAT_READY", rx_ready_o, lat_exp);
            if (t == ack_tick && ack_chk) check("ACK_CLR", rx_ready_o, 0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic idle_bit();
        send_bit(1'b1, -1, 1'b0, -1, 1'b0, 16);
    endtask

    // Line reaches the FSM one tick late, so start is seen at tick 1 and every
    // sample (start mid, data bits, stop) lands on tick 9 of its bit cell.
    // ack_mode: 0 none, 1 ack on the stop-sample edge, 2 ack later in the stop bit
    task automatic send_frame(input logic [7:0] data, input logic stop, input int ack_mode,
                              input int idle_bits);
        ev_t  e;
        logic lat;
        int   ack_tick;
        if (stop) begin
            e.kind      = (ack_mode != 1 && model_ready) ? 2 : 3;
            model_data  = data;
            model_ready = 1'b1;
        end else begin
            e.kind = 1;
            if (ack_mode == 1) model_ready = 1'b0;
        end
        e.data  = model_data;
        e.ready = model_ready;
        lat     = model_ready;
        exp_q.push_back(e);
        ack_tick = (ack_mode == 1) ? 9 : (ack_mode == 2) ? 12 : -1;
        send_bit(1'b0, -1, 1'b0, -1, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(data[i], -1, 1'b0, -1, 1'b0, 16);
        send_bit(stop, ack_tick, (ack_mode == 2), 9, lat, 16);
        if (ack_mode == 2) model_ready = 1'b0;
        for (int i = 0; i < idle_bits; i++) idle_bit();
    endtask

    // Monitor: a completion is a pulse, or ready high when it was low or just acked
    initial begin
        logic ready_prev;
        logic ld;
        int   kind;
        ev_t  e;
        ready_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ready_prev = 1'b0;
            end else begin
                ld = rx_ready_o && (!ready_prev || rx_ack_i);
                if (frame_err_o || overrun_o || ld) begin
                    if (frame_err_o)    kind = (overrun_o || ld) ? 0 : 1;
                    else if (overrun_o) kind = 2;
                    else                kind = 3;
                    $display("rx event kind=%0d data=%02h ready=%0b", kind, rx_data_o, rx_ready_o);
                    if (exp_q.size() == 0) begin
                        check("UNEXPECTED_EVENT", kind, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("EV_KIND", kind, e.kind);
                        check("EV_DATA", rx_data_o, e.data);
                        check("EV_READY", rx_ready_o, e.ready);
                    end
                end
                ready_prev = rx_ready_o;
            end
        end
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         rm;
        int         ri;
        rst_n       = 1'b0;
        ce16_i      = 1'b0;
        ser_in      = 1'b1;
        rx_ack_i    = 1'b0;
        model_ready = 1'b0;
        model_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("RST_DATA", rx_data_o, 8'h00);
        check("RST_READY", rx_ready_o, 0);
        check("RST_FERR", frame_err_o, 0);
        check("RST_OVR", overrun_o, 0);
        rst_n = 1'b1;
        idle_bit();
        idle_bit();

        send_frame(8'hA5, 1'b1, 2, 1);

        // Short low glitch must be rejected at mid start bit
        send_bit(1'b0, -1, 1'b0, -1, 1'b0, 4);
        idle_bit();
        idle_bit();
        check("GLITCH_READY", rx_ready_o, 0);
        check("GLITCH_DATA", rx_data_o, 8'hA5);

        send_frame(8'h55, 1'b0, 0, 1);

        send_frame(8'h12, 1'b1, 0, 1);
        send_frame(8'h34, 1'b1, 2, 1);
        send_frame(8'h12, 1'b1, 0, 1);
        send_frame(8'h34, 1'b1, 1, 1);

        // Reset during data bit 4 of 0xFF while a byte is still unread
        send_bit(1'b0, -1, 1'b0, -1, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1, 1'b0, -1, 1'b0, 16);
        send_bit(1'b1, -1, 1'b0, -1, 1'b0, 8);
        #3;
        rst_n  = 1'b0;
        ser_in = 1'b1;
        #1;
        check("MIDRST_DATA", rx_data_o, 8'h00);
        check("MIDRST_READY", rx_ready_o, 0);
        check("MIDRST_FERR", frame_err_o, 0);
        check("MIDRST_OVR", overrun_o, 0);
        model_ready = 1'b0;
        model_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bit();
        idle_bit();
        send_frame(8'h3C, 1'b1, 2, 1);

        send_frame(8'h00, 1'b1, 2, 1);
        send_frame(8'hFF, 1'b1, 2, 1);
        send_frame(8'h80, 1'b1, 2, 1);

        for (int n = 0; n < 30; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            rm = $urandom_range(0, 2);
            ri = $urandom_range(rs ? 0 : 1, 2);
            send_frame(rb, rs, rm, ri);
        end

        idle_bit();
        idle_bit();
        check("QUEUE_EMPTY", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
